// File: rtl/fetch_sequencer.sv
// Purpose : Opcode fetch / execute-cycle sequencer. It injects BRK (8'h00) for
//           RESET, NMI and IRQ, counts execute cycles T1..T7 and flags runaway
//           instructions.
// Ports   : fclk/reset (sync, active-high); cycle_en & rdy form "advance";
//           data_in/instr_done come from the bus and decoder; nmi/irq/irq_mask
//           are the interrupt inputs; outputs are ir_signal, opcode_out, sync,
//           t_state, pc_inc, vector_sel and timeout_err.
// Timing  : ir_signal and pc_inc are combinational in the advance cycle. All
//           other outputs are registered and update on the advancing edge.
//           With rdy=0 every register holds, except the NMI edge detector.
module fetch_sequencer (
    input  logic       fclk,
    input  logic       reset,
    input  logic       cycle_en,
    input  logic       rdy,
    input  logic [7:0] data_in,
    input  logic       instr_done,
    input  logic       nmi,
    input  logic       irq,
    input  logic       irq_mask,
    output logic       ir_signal,
    output logic [7:0] opcode_out,
    output logic       sync,
    output logic [2:0] t_state,
    output logic       pc_inc,
    output logic [1:0] vector_sel,
    output logic       timeout_err
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_e;

    localparam logic [7:0] OP_BRK = 8'h00;
    localparam logic [7:0] OP_NOP = 8'hEA;

    localparam logic [1:0] VEC_NONE  = 2'b00;
    localparam logic [1:0] VEC_IRQ   = 2'b01;
    localparam logic [1:0] VEC_NMI   = 2'b10;
    localparam logic [1:0] VEC_RESET = 2'b11;

    state_e     state_q, state_d;
    logic [2:0] t_q, t_d;
    logic [7:0] opcode_q, opcode_d;
    logic [1:0] vsel_q, vsel_d;
    logic       timeout_q, timeout_d;
    logic       reset_pend_q, reset_pend_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_smp_q;

    logic advance;
    logic nmi_edge;
    logic nmi_clr;
    logic ir_raw;
    logic pc_raw;

    assign advance  = cycle_en & rdy;
    assign nmi_edge = nmi & ~nmi_smp_q;

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        opcode_d     = opcode_q;
        vsel_d       = vsel_q;
        timeout_d    = timeout_q;
        reset_pend_d = reset_pend_q;
        nmi_clr      = 1'b0;
        ir_raw       = 1'b0;
        pc_raw       = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (advance) begin
                    ir_raw  = 1'b1;
                    state_d = S_EXEC;
                    t_d     = 3'd1;
                    if (reset_pend_q) begin
                        opcode_d     = OP_BRK;
                        vsel_d       = VEC_RESET;
                        reset_pend_d = 1'b0;
                    end else if (nmi_pend_q) begin
                        opcode_d = OP_BRK;
                        vsel_d   = VEC_NMI;
                        nmi_clr  = 1'b1;
                    end else if (irq && !irq_mask) begin
                        // IRQ is level sensitive and has no pending flag.
                        // The source must hold the line until it is serviced.
                        opcode_d = OP_BRK;
                        vsel_d   = VEC_IRQ;
                    end else begin
                        opcode_d = data_in;
                        vsel_d   = VEC_NONE;
                        pc_raw   = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (advance) begin
                    if (instr_done) begin
                        state_d = S_FETCH;
                        t_d     = 3'd0;
                    end else if (t_q == 3'd7) begin
                        // Abandon the runaway instruction and refetch.
                        state_d   = S_FETCH;
                        t_d       = 3'd0;
                        timeout_d = 1'b1;
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
            end
        endcase

        // A new edge that lands on the service edge wins, so that NMI is not lost.
        nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_edge;
    end

    always_ff @(posedge fclk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            t_q          <= 3'd0;
            opcode_q     <= OP_NOP;
            vsel_q       <= VEC_NONE;
            timeout_q    <= 1'b0;
            reset_pend_q <= 1'b1;
            nmi_pend_q   <= 1'b0;
            nmi_smp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            opcode_q     <= opcode_d;
            vsel_q       <= vsel_d;
            timeout_q    <= timeout_d;
            reset_pend_q <= reset_pend_d;
            nmi_pend_q   <= nmi_pend_d;
            nmi_smp_q    <= nmi;
        end
    end

    // Reset takes priority over an in-flight advance. No strobes fire in the reset cycle.
    assign ir_signal   = ir_raw & ~reset;
    assign pc_inc      = pc_raw & ~reset;
    assign opcode_out  = opcode_q;
    assign sync        = (state_q == S_FETCH);
    assign t_state     = t_q;
    assign vector_sel  = vsel_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic       fclk = 1'b0;
    logic       reset;
    logic       cycle_en;
    logic       rdy;
    logic [7:0] data_in;
    logic       instr_done;
    logic       nmi;
    logic       irq;
    logic       irq_mask;
    logic       ir_signal;
    logic [7:0] opcode_out;
    logic       sync;
    logic [2:0] t_state;
    logic       pc_inc;
    logic [1:0] vector_sel;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer dut (
        .fclk        (fclk),
        .reset       (reset),
        .cycle_en    (cycle_en),
        .rdy         (rdy),
        .data_in     (data_in),
        .instr_done  (instr_done),
        .nmi         (nmi),
        .irq         (irq),
        .irq_mask    (irq_mask),
        .ir_signal   (ir_signal),
        .opcode_out  (opcode_out),
        .sync        (sync),
        .t_state     (t_state),
        .pc_inc      (pc_inc),
        .vector_sel  (vector_sel),
        .timeout_err (timeout_err)
    );

    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge. Combinational checks are made after a further 1 ns.
    task automatic drive(input logic cen, input logic r, input logic [7:0] d, input logic done);
        cycle_en   = cen;
        rdy        = r;
        data_in    = d;
        instr_done = done;
        #1;
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cycle_en = 1'b1; rdy = 1'b1; data_in = 8'hA9;
        instr_done = 1'b0; nmi = 1'b0; irq = 1'b0; irq_mask = 1'b0;

        // Reset overrides a live advance.
        tick();
        drive(1, 1, 8'hA9, 0);
        check("rst_ir", ir_signal, 1'b0);
        check("rst_pc", pc_inc, 1'b0);
        tick();
        check("rst_sync", sync, 1'b1);
        check("rst_t", t_state, 3'd0);
        check("rst_op", opcode_out, 8'hEA);
        check("rst_vsel", vector_sel, 2'b00);
        check("rst_to", timeout_err, 1'b0);

        // The first fetch after reset injects the RESET vector.
        reset = 1'b0;
        drive(1, 1, 8'hA9, 0);
        check("rv_ir", ir_signal, 1'b1);
        check("rv_pc", pc_inc, 1'b0);
        tick();
        check("rv_op", opcode_out, 8'h00);
        check("rv_vsel", vector_sel, 2'b11);
        check("rv_t", t_state, 3'd1);
        check("rv_sync", sync, 1'b0);
        drive(1, 1, 8'hA9, 1);
        tick();
        check("rv_back", sync, 1'b1);
        check("rv_t0", t_state, 3'd0);

        // Normal fetch of A9, with one non-advancing cycle in EXEC.
        drive(1, 1, 8'hA9, 0);
        check("lda_ir", ir_signal, 1'b1);
        check("lda_pc", pc_inc, 1'b1);
        tick();
        check("lda_op", opcode_out, 8'hA9);
        check("lda_vsel", vector_sel, 2'b00);
        check("lda_t", t_state, 3'd1);
        check("lda_exec_pc", pc_inc, 1'b0);
        drive(0, 1, 8'h00, 1);
        tick();
        check("lda_hold_t", t_state, 3'd1);
        check("lda_hold_sync", sync, 1'b0);
        check("lda_hold_op", opcode_out, 8'hA9);
        drive(1, 1, 8'h00, 1);
        tick();
        check("lda_back", sync, 1'b1);

        // IRQ unmasked, then masked.
        irq = 1'b1; irq_mask = 1'b0;
        drive(1, 1, 8'h55, 0);
        check("irq_pc", pc_inc, 1'b0);
        tick();
        check("irq_op", opcode_out, 8'h00);
        check("irq_vsel", vector_sel, 2'b01);
        drive(1, 1, 8'h55, 1);
        tick();
        irq_mask = 1'b1;
        drive(1, 1, 8'h55, 0);
        check("mask_pc", pc_inc, 1'b1);
        tick();
        check("mask_op", opcode_out, 8'h55);
        check("mask_vsel", vector_sel, 2'b00);

        // NMI pulse while stalled by rdy=0 in EXEC.
        drive(1, 0, 8'h55, 0);
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        tick();
        check("stall_t", t_state, 3'd1);
        check("stall_op", opcode_out, 8'h55);
        check("stall_sync", sync, 1'b0);
        irq_mask = 1'b0;
        drive(1, 1, 8'h55, 1);
        tick();
        // Both NMI and IRQ are pending, and NMI wins.
        drive(1, 1, 8'h55, 0);
        check("nmi_pc", pc_inc, 1'b0);
        tick();
        check("nmi_op", opcode_out, 8'h00);
        check("nmi_vsel", vector_sel, 2'b10);
        drive(1, 1, 8'h55, 1);
        tick();
        drive(1, 1, 8'h55, 0);
        tick();
        check("irq_next_vsel", vector_sel, 2'b01);
        drive(1, 1, 8'h55, 1);
        tick();

        // An NMI edge that arrives on the service edge stays pending.
        irq = 1'b0;
        drive(0, 1, 8'h33, 0);
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        tick();
        drive(1, 1, 8'h33, 0);
        nmi = 1'b1;
        tick();
        check("nmi2_vsel", vector_sel, 2'b10);
        drive(1, 1, 8'h33, 1);
        tick();
        drive(1, 1, 8'h33, 0);
        tick();
        check("nmi_same_edge", vector_sel, 2'b10);
        nmi = 1'b0;
        drive(1, 1, 8'h33, 1);
        tick();

        // Timeout: instr_done never asserts.
        drive(1, 1, 8'h20, 0);
        tick();
        check("to_t1", t_state, 3'd1);
        for (int i = 2; i <= 7; i++) begin
            tick();
            check("to_t", t_state, i[2:0]);
        end
        check("to_pre", timeout_err, 1'b0);
        tick();
        check("to_sync", sync, 1'b1);
        check("to_t0", t_state, 3'd0);
        check("to_err", timeout_err, 1'b1);
        drive(1, 1, 8'h20, 0);
        tick();
        drive(1, 1, 8'h20, 1);
        tick();
        check("to_sticky", timeout_err, 1'b1);
        check("to_op", opcode_out, 8'h20);

        // rdy=0 in FETCH holds everything.
        drive(1, 0, 8'h77, 0);
        for (int i = 0; i < 3; i++) begin
            check("rdy0_ir", ir_signal, 1'b0);
            check("rdy0_pc", pc_inc, 1'b0);
            tick();
            check("rdy0_sync", sync, 1'b1);
            check("rdy0_t", t_state, 3'd0);
            check("rdy0_op", opcode_out, 8'h20);
        end
        drive(1, 1, 8'h77, 0);
        check("rdy1_ir", ir_signal, 1'b1);
        check("rdy1_pc", pc_inc, 1'b1);
        tick();
        check("rdy1_op", opcode_out, 8'h77);

        // Reset in the middle of an instruction.
        drive(1, 1, 8'h77, 0);
        tick();
        check("mid_t2", t_state, 3'd2);
        reset = 1'b1;
        tick();
        check("mid_sync", sync, 1'b1);
        check("mid_t", t_state, 3'd0);
        check("mid_op", opcode_out, 8'hEA);
        check("mid_to", timeout_err, 1'b0);
        reset = 1'b0;
        drive(1, 1, 8'h77, 0);
        check("mid_pc", pc_inc, 1'b0);
        tick();
        check("mid_vsel", vector_sel, 2'b11);
        check("mid_inj", opcode_out, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
